// File: rtl/b1_scfifo_reader_if.sv
// Downstream valid/ready stream carried between the b1 FIFO reader and its consumer.
// master = the reader (drives data/valid), slave = the consumer (drives ready).
interface b1_scfifo_reader_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] data_o;
    logic              valid_o;
    logic              ready_i;

    modport master (
        output data_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/b1_scfifo_reader.sv
// Read-side consumer for the b1 single-clock FIFO (normal mode): issues credit-limited
// read requests, absorbs the one-cycle read latency in a 2-entry buffer, streams out.
module b1_scfifo_reader #(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 fifo_empty_i,
    input  logic [DWIDTH-1:0]    fifo_q_i,
    output logic                 fifo_rdreq_o,
    b1_scfifo_reader_if.master   strm,
    output logic [1:0]           level_o,
    output logic [CWIDTH-1:0]    words_o
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              inflight_q;
    logic [DWIDTH-1:0] head_q;
    logic [DWIDTH-1:0] tail_q;
    logic [CWIDTH-1:0] words_q;
    logic              pop;
    logic [2:0]        occ_next;
    logic              cap_head;

    assign strm.valid_o = (state_q != ST_EMPTY);
    assign strm.data_o  = head_q;
    assign level_o      = state_q;
    assign words_o      = words_q;

    assign pop = strm.valid_o && strm.ready_i;

    // Occupancy after this cycle counting the word in flight; a read is only issued
    // when that still leaves a free slot for the data returning next cycle.
    assign occ_next     = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rdreq_o = arstn_i && !fifo_empty_i && (occ_next < 3'd2);

    // Incoming word lands in head only if the buffer drains to nothing this cycle.
    assign cap_head = (state_q == ST_EMPTY) || ((state_q == ST_ONE) && pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (inflight_q) state_d = ST_ONE;
            end
            ST_ONE: begin
                if (inflight_q && !pop)      state_d = ST_TWO;
                else if (pop && !inflight_q) state_d = ST_EMPTY;
            end
            ST_TWO: begin
                if (pop && !inflight_q) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= ST_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rdreq_o;
            if (pop) words_q <= words_q + CWIDTH'(1);
            if (pop && (state_q == ST_TWO)) head_q <= tail_q;
            if (inflight_q) begin
                if (cap_head) head_q <= fifo_q_i;
                else          tail_q <= fifo_q_i;
            end
        end
    end
endmodule

// File: tb/tb_b1_scfifo_reader.sv
// Scoreboard bench for b1_scfifo_reader with a queue-based FIFO model feeding the DUT.
module tb_b1_scfifo_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_q = '0;
    logic          rdreq;
    logic [1:0]    level;
    logic [CW-1:0] words;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    b1_scfifo_reader_if #(.DWIDTH(DW)) strm();

    b1_scfifo_reader #(.DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .fifo_empty_i (fifo_empty),
        .fifo_q_i     (fifo_q),
        .fifo_rdreq_o (rdreq),
        .strm         (strm.master),
        .level_o      (level),
        .words_o      (words)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural normal-mode FIFO: q is registered on a read request.
    logic [DW-1:0] mem[$];
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mem.delete();
            fifo_empty <= 1'b1;
            fifo_q     <= '0;
        end else begin
            if (rdreq && mem.size() > 0) fifo_q <= mem.pop_front();
            if (wr_en) mem.push_back(wr_data);
            fifo_empty <= (mem.size() == 0);
        end
    end

    // Scoreboard and occupancy model: buffer holds words read minus words delivered.
    logic [DW-1:0] exp_q[$];
    int   occ = 0, inflight_m = 0, delivered = 0;
    int   rd_cycles = 0, valid_cycles = 0, cyc = 0, first_x = -1, last_x = -1;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!arstn) begin
            occ = 0; inflight_m = 0; delivered = 0;
            rd_cycles = 0; valid_cycles = 0; cyc = 0; first_x = -1; last_x = -1;
            prev_stall = 1'b0;
        end else begin
            automatic int pop = (strm.valid_o && strm.ready_i) ? 1 : 0;
            automatic logic exp_rd = !fifo_empty && ((occ + inflight_m - pop) < 2);
            check("valid", strm.valid_o, occ != 0);
            check("level", level, occ);
            check("words", words, delivered % (1 << CW));
            check("rdreq", rdreq, exp_rd);
            check("rd_when_empty", rdreq && fifo_empty, 0);
            n_checks++;
            assert (!(inflight_m == 1 && level == 2'd2 && pop == 0)) n_pass++;
            else $display("FAIL cap_two: capture into full buffer without pop at %0t", $time);
            if (prev_stall) begin
                check("stall_valid", strm.valid_o, 1);
                check("stall_data", strm.data_o, prev_data);
            end
            if (pop == 1) begin
                if (exp_q.size() == 0) check("unexpected_word", strm.data_o, 32'hDEAD);
                else check("data", strm.data_o, exp_q.pop_front());
                delivered++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            rd_cycles    += rdreq ? 1 : 0;
            valid_cycles += strm.valid_o ? 1 : 0;
            occ        = occ + inflight_m - pop;
            inflight_m = rdreq ? 1 : 0;
            prev_stall = strm.valid_o && !strm.ready_i;
            prev_data  = strm.data_o;
            cyc++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #3;
        arstn = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", strm.valid_o, 0);
        check("rst_level", level, 0);
        check("rst_words", words, 0);
        check("rst_rdreq", rdreq, 0);
        @(posedge clk); @(posedge clk); #3;
        arstn = 1'b1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
    endtask

    task automatic end_writes();
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_delivered(input int n, input int budget, input string tag);
        int k = 0;
        while (delivered < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_timeout"}, delivered >= n, 1);
    endtask

    initial begin
        strm.ready_i = 1'b0;

        // Single word
        do_reset();
        strm.ready_i = 1'b1;
        write_word(8'hA5);
        end_writes();
        wait_delivered(1, 50, "single");
        repeat (3) @(posedge clk);
        #1;
        check("single_rd_cycles", rd_cycles, 1);
        check("single_valid_cycles", valid_cycles, 1);
        check("single_words", words, 1);
        check("single_level", level, 0);

        // Streaming, no bubbles after the first transfer
        do_reset();
        strm.ready_i = 1'b1;
        for (int i = 0; i < 16; i++) write_word(8'(i));
        end_writes();
        wait_delivered(16, 100, "stream");
        repeat (2) @(posedge clk);
        #1;
        check("stream_span", last_x - first_x, 15);
        check("stream_words", words, 16 % (1 << CW));
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: prefetch two then hold
        do_reset();
        strm.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'(8'h10 + i));
        end_writes();
        repeat (6) @(posedge clk);
        #1;
        check("bp_level", level, 2);
        check("bp_rdreq", rdreq, 0);
        check("bp_data", strm.data_o, 8'h10);
        @(posedge clk); #1;
        check("bp_data_hold", strm.data_o, 8'h10);
        @(posedge clk); #1;
        strm.ready_i = 1'b1;
        #1;
        check("bp_release_rdreq", rdreq, 1);
        wait_delivered(5, 50, "bp");
        check("bp_drained", exp_q.size(), 0);

        // Random ready and write pattern
        do_reset();
        begin
            int sent = 0;
            for (int c = 0; c < 2000 && delivered < 32; c++) begin
                @(posedge clk); #1;
                strm.ready_i = 1'($urandom_range(0, 1));
                if (sent < 32 && $urandom_range(0, 1) == 1) begin
                    wr_en   = 1'b1;
                    wr_data = 8'($urandom);
                    exp_q.push_back(wr_data);
                    sent++;
                end else begin
                    wr_en = 1'b0;
                end
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            strm.ready_i = 1'b1;
            check("rand_sent", sent, 32);
        end
        wait_delivered(32, 200, "rand");
        check("rand_drained", exp_q.size(), 0);

        // Reset mid-stream with a full buffer and words left in the FIFO
        do_reset();
        strm.ready_i = 1'b1;
        write_word(8'h2F);
        end_writes();
        wait_delivered(1, 50, "mid_pre");
        @(posedge clk); #1;
        strm.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'(8'h30 + i));
        end_writes();
        begin
            int k = 0;
            while (level != 2'd2 && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            check("mid_reach_two", level, 2);
        end
        check("mid_words_before", words, 1);
        @(posedge clk); #3;
        arstn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_valid", strm.valid_o, 0);
        check("mid_level", level, 0);
        check("mid_words", words, 0);
        check("mid_rdreq", rdreq, 0);
        @(posedge clk); @(posedge clk); #3;
        arstn = 1'b1;
        strm.ready_i = 1'b1;
        write_word(8'h3C);
        end_writes();
        wait_delivered(1, 50, "mid_post");
        repeat (2) @(posedge clk);
        #1;
        check("mid_post_words", words, 1);

        // Counter wrap at 4 bits: 17 words leave the counter at 1
        do_reset();
        strm.ready_i = 1'b1;
        for (int i = 0; i < 17; i++) write_word(8'(8'h40 + i));
        end_writes();
        wait_delivered(17, 100, "wrap");
        repeat (2) @(posedge clk);
        #1;
        check("wrap_words", words, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
